ysyx_24100029_wbu_queue: RTL and testbench

Parametrised write-back stage that replaces the single-register write-back with a DEPTH-entry in-order retire queue and real backpressure.
- Accepts completed instructions from MEM over valid/ready.
- Retires at most one per cycle into the register file and CSR file.
- Drives commit (pc/inst) for difftest.
- Exports a pending-destination mask for ID-stage hazard detection.

---
 rtl/ysyx_24100029_wbu_queue.sv | 157 +++++++++++++++
 tb/tb_ysyx_24100029_wbu_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_wbu_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24100029_wbu_queue
//  Brief    : Write-back stage built as a DEPTH-entry in-order retire queue.
//             Accepts completed instructions from MEM over valid/ready,
//             retires at most one per cycle into the RF/CSR file, drives the
//             difftest commit port and exports a pending-destination mask.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100029_wbu_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int NREG  = 32,
    parameter int CSRW  = 4,
    localparam int RW   = $clog2(NREG),
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clock,
    input  logic            reset,
    // MEM -> WB handshake and payload
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_ex_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [XLEN-1:0] in_csrs,
    input  logic [RW-1:0]   in_rd,
    input  logic [CSRW-1:0] in_csr_wen,
    input  logic            in_r_wen,
    input  logic            in_mem_ren,
    input  logic            in_jump_flag,
    input  logic            wb_stall,
    // register file / CSR file write port
    output logic            rf_wen,
    output logic [RW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [CSRW-1:0] csr_wen_o,
    output logic [XLEN-1:0] csr_wdata,
    // difftest commit
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_inst,
    // hazard detection
    output logic [NREG-1:0] busy_mask,
    output logic [CW-1:0]   count
);

    // Entry storage; contents are don't-care until the entry is occupied.
    logic [XLEN-1:0] pc_q     [DEPTH];
    logic [31:0]     inst_q   [DEPTH];
    logic [XLEN-1:0] ex_q     [DEPTH];
    logic [XLEN-1:0] mrd_q    [DEPTH];
    logic [XLEN-1:0] csrs_q   [DEPTH];
    logic [RW-1:0]   rd_q     [DEPTH];
    logic [CSRW-1:0] csrw_q   [DEPTH];
    logic            rwen_q   [DEPTH];
    logic            mren_q   [DEPTH];
    logic            jmp_q    [DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            retire;
    logic            push;

    // Retire is decided purely from registered state, so an entry pushed at
    // an edge can never leave in that same cycle (no bypass).
    assign retire   = (count_q != '0) && !wb_stall;
    assign in_ready = (count_q < CW'(DEPTH)) || retire;
    assign push     = in_valid && in_ready;
    assign count    = count_q;

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
        if (retire) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset empties the queue at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture the offered instruction into the tail slot.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_q[wr_ptr_q]   <= in_pc;
            inst_q[wr_ptr_q] <= in_inst;
            ex_q[wr_ptr_q]   <= in_ex_result;
            mrd_q[wr_ptr_q]  <= in_mem_rdata;
            csrs_q[wr_ptr_q] <= in_csrs;
            rd_q[wr_ptr_q]   <= in_rd;
            csrw_q[wr_ptr_q] <= in_csr_wen;
            rwen_q[wr_ptr_q] <= in_r_wen;
            mren_q[wr_ptr_q] <= in_mem_ren;
            jmp_q[wr_ptr_q]  <= in_jump_flag;
        end
    end

    // Head-of-queue outputs, all forced to zero when nothing retires.
    always_comb begin
        logic [XLEN-1:0] wsel;
        if (jmp_q[rd_ptr_q])
            wsel = pc_q[rd_ptr_q] + XLEN'(4);
        else if (mren_q[rd_ptr_q])
            wsel = mrd_q[rd_ptr_q];
        else if (csrw_q[rd_ptr_q] != '0)
            wsel = csrs_q[rd_ptr_q];
        else
            wsel = ex_q[rd_ptr_q];

        commit_valid = retire;
        commit_pc    = retire ? pc_q[rd_ptr_q]   : '0;
        commit_inst  = retire ? inst_q[rd_ptr_q] : '0;
        // x0 writes are dropped but the instruction still commits.
        rf_wen       = retire && rwen_q[rd_ptr_q] && (rd_q[rd_ptr_q] != '0);
        rf_waddr     = rf_wen ? rd_q[rd_ptr_q] : '0;
        rf_wdata     = rf_wen ? wsel : '0;
        csr_wen_o    = retire ? csrw_q[rd_ptr_q] : '0;
        csr_wdata    = retire ? ex_q[rd_ptr_q]   : '0;
    end

    // Pending destinations of every occupied slot, head included until it
    // has actually left the queue.
    always_comb begin
        logic [PW-1:0] offs;
        busy_mask = '0;
        offs      = '0;
        for (int e = 0; e < DEPTH; e++) begin
            offs = PW'(e) - rd_ptr_q;
            if (({1'b0, offs} < count_q) && rwen_q[e])
                busy_mask[rd_q[e]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100029_wbu_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_24100029_wbu_queue
//  Brief    : Scoreboard bench for the write-back retire queue. Stimulus
//             pushes hand-computed expected commits into a queue; a monitor
//             pops and compares on every retire.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100029_wbu_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst, in_ex_result, in_mem_rdata, in_csrs;
    logic [4:0]  in_rd;
    logic [3:0]  in_csr_wen;
    logic        in_r_wen, in_mem_ren, in_jump_flag, wb_stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  csr_wen_o;
    logic [31:0] csr_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_inst;
    logic [31:0] busy_mask;
    logic [1:0]  count;

    ysyx_24100029_wbu_queue #(.XLEN(32), .DEPTH(2), .NREG(32), .CSRW(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_ex_result(in_ex_result),
        .in_mem_rdata(in_mem_rdata), .in_csrs(in_csrs), .in_rd(in_rd),
        .in_csr_wen(in_csr_wen), .in_r_wen(in_r_wen), .in_mem_ren(in_mem_ren),
        .in_jump_flag(in_jump_flag), .wb_stall(wb_stall),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_wen_o(csr_wen_o), .csr_wdata(csr_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .busy_mask(busy_mask), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rfwen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  csrw;
        logic [31:0] csrd;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_commit = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every retire; idle cycles must show zeros.
    always @(negedge clock) begin
        if (!reset) begin
            if (commit_valid === 1'b1) begin
                n_commit++;
                if (sb.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_commit: got pc %h expected none", commit_pc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("commit_pc",   commit_pc,   e.pc);
                    check("commit_inst", commit_inst, e.inst);
                    check("rf_wen",      {31'b0, rf_wen},    {31'b0, e.rfwen});
                    check("rf_waddr",    {27'b0, rf_waddr},  {27'b0, e.waddr});
                    check("rf_wdata",    rf_wdata,    e.wdata);
                    check("csr_wen_o",   {28'b0, csr_wen_o}, {28'b0, e.csrw});
                    check("csr_wdata",   csr_wdata,   e.csrd);
                end
            end else begin
                check("idle_zero",
                      {31'b0, rf_wen} | {27'b0, rf_waddr} | rf_wdata | {28'b0, csr_wen_o}
                      | csr_wdata | commit_pc | commit_inst, 32'h0);
            end
        end
    end

    task automatic drive(input logic [31:0] pc, inst, ex, mrd, csrs,
                         input logic [4:0] rd, input logic [3:0] csrw,
                         input logic rwen, mren, jmp);
        in_pc = pc; in_inst = inst; in_ex_result = ex; in_mem_rdata = mrd;
        in_csrs = csrs; in_rd = rd; in_csr_wen = csrw; in_r_wen = rwen;
        in_mem_ren = mren; in_jump_flag = jmp; in_valid = 1'b1;
    endtask

    // Offer one instruction and wait (bounded) for acceptance; in_valid stays
    // high afterwards so consecutive calls are back-to-back.
    task automatic push(input logic [31:0] pc, inst, ex, mrd, csrs,
                        input logic [4:0] rd, input logic [3:0] csrw,
                        input logic rwen, mren, jmp, input logic [31:0] exp_wdata);
        logic ok;
        exp_t e;
        drive(pc, inst, ex, mrd, csrs, rd, csrw, rwen, mren, jmp);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            if (ok) begin
                e.pc    = pc;
                e.inst  = inst;
                e.rfwen = rwen && (rd != 5'd0);
                e.waddr = e.rfwen ? rd : 5'd0;
                e.wdata = e.rfwen ? exp_wdata : 32'h0;
                e.csrw  = csrw;
                e.csrd  = ex;
                sb.push_back(e);
                return;
            end
        end
        n_vec++; n_fail++;
        $display("FAIL push_timeout: got no in_ready expected accept pc %h", pc);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, k0;
        reset = 1'b1; wb_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        @(negedge clock);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_count",    {30'b0, count},    32'h0);
        check("rst_busy",     busy_mask,         32'h0);
        check("rst_commit",   {31'b0, commit_valid}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle(1);

        // Single addi x1 = 5; retires the cycle after acceptance.
        push(32'h80000000, 32'h00500093, 32'd5, 0, 0, 5'd1, 4'd0, 1, 0, 0, 32'd5);
        in_valid = 1'b0;
        @(negedge clock);
        check("t1_commit_valid", {31'b0, commit_valid}, 32'h1);
        check("t1_busy",         busy_mask,             32'h2);
        check("t1_count",        {30'b0, count},        32'h1);
        @(negedge clock);
        check("t1_count_after",  {30'b0, count},        32'h0);
        check("t1_busy_after",   busy_mask,             32'h0);
        idle(1);

        // Write-data priority: jump (wrapping), load, CSR read value.
        push(32'hFFFFFFFC, 32'h0000006F, 32'h11, 32'h22, 32'h33, 5'd1, 4'd0, 1, 1, 1, 32'h00000000);
        push(32'h80000010, 32'h00002103, 32'h10, 32'hDEADBEEF, 32'h44, 5'd2, 4'd1, 1, 1, 0, 32'hDEADBEEF);
        push(32'h80000014, 32'h30029273, 32'h88, 32'h55, 32'h1800, 5'd5, 4'd1, 1, 0, 0, 32'h00001800);
        idle(3);

        // Stall: fill to DEPTH, third offer held, then release.
        wb_stall = 1'b1;
        push(32'h80000100, 32'h00000193, 32'h300, 0, 0, 5'd3, 4'd0, 1, 0, 0, 32'h300);
        push(32'h80000104, 32'h00000213, 32'h400, 0, 0, 5'd4, 4'd0, 1, 0, 0, 32'h400);
        drive(32'h80000108, 32'h00000293, 32'h500, 0, 0, 5'd5, 4'd0, 1, 0, 0);
        @(negedge clock);
        check("stall_in_ready", {31'b0, in_ready},     32'h0);
        check("stall_count",    {30'b0, count},        32'h2);
        check("stall_busy",     busy_mask,             32'h18);
        check("stall_commit",   {31'b0, commit_valid}, 32'h0);
        @(posedge clock); #1;
        check("stall_count_hold", {30'b0, count},      32'h2);
        wb_stall = 1'b0;
        push(32'h80000108, 32'h00000293, 32'h500, 0, 0, 5'd5, 4'd0, 1, 0, 0, 32'h500);
        in_valid = 1'b0;
        @(negedge clock);
        check("full_retire_count", {30'b0, count},     32'h2);
        check("full_retire_busy",  busy_mask,          32'h30);
        idle(3);

        // x0 destination: commits, but no register write.
        push(32'h80000200, 32'h00000013, 32'h1234, 0, 0, 5'd0, 4'd0, 1, 0, 0, 32'h0);
        in_valid = 1'b0;
        @(negedge clock);
        check("x0_commit_valid", {31'b0, commit_valid}, 32'h1);
        check("x0_busy",         busy_mask,             32'h0);
        idle(2);

        // Streaming: 20 back-to-back pushes, one per cycle.
        c0 = cyc; k0 = n_commit;
        for (int i = 0; i < 20; i++)
            push(32'h80001000 + 32'(4 * i), 32'h00000013 + 32'(i), 32'(3 * i + 7), 0, 0,
                 5'(i % 7 + 1), 4'd0, 1, 0, 0, 32'(3 * i + 7));
        check("stream_cycles", 32'(cyc - c0), 32'd20);
        idle(2);
        check("stream_commits", 32'(n_commit - k0), 32'd20);

        // Asynchronous reset with two stalled entries.
        wb_stall = 1'b1;
        push(32'h80002000, 32'h00000093, 32'h1, 0, 0, 5'd6, 4'd0, 1, 0, 0, 32'h1);
        push(32'h80002004, 32'h00000093, 32'h2, 0, 0, 5'd7, 4'd0, 1, 0, 0, 32'h2);
        in_valid = 1'b0;
        @(negedge clock);
        check("prerst_count", {30'b0, count}, 32'h2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count",    {30'b0, count},        32'h0);
        check("arst_commit",   {31'b0, commit_valid}, 32'h0);
        check("arst_busy",     busy_mask,             32'h0);
        check("arst_in_ready", {31'b0, in_ready},     32'h1);
        sb.delete();
        wb_stall = 1'b0;
        @(posedge clock); #3;
        reset = 1'b0;
        k0 = n_commit;
        idle(4);
        check("no_stale_commit", 32'(n_commit - k0), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
